// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//
// Multi-digit 7-segment display controller.  A captured binary value is
// saturated to the largest value the digits can show, converted to BCD by a
// sequential shift-and-add-3 engine, and then time-multiplexed across the
// digits by a free-running refresh divider.  Leading zeros can optionally be
// blanked.
//
// Parameters:
//   WIDTH        binary input width (>= 4)
//   DIGITS       number of displayed digits (2..8)
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   bin_in    binary value to display
//   load      capture strobe, honoured only while busy is low
//   blank_lz  1 = blank leading zeros
//   an_en     digit enables, active-high, one-hot or zero, bit 0 = units
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   busy      conversion in progress
//   overflow  last converted value was saturated
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  bin_in,
    input  logic              load,
    input  logic              blank_lz,
    output logic [DIGITS-1:0] an_en,
    output logic [6:0]        seg,
    output logic              busy,
    output logic              overflow
);

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    localparam int MAXV = pow10(DIGITS) - 1;
    // Comparison width large enough for both the input and the saturation limit
    localparam int CW   = (WIDTH > 32) ? WIDTH : 32;
    localparam int BW   = DIGITS * 4;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int RW   = $clog2(REFRESH_DIV);
    localparam int SW   = $clog2(DIGITS);
    localparam logic [CW-1:0] MAXV_EXT = CW'(MAXV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_next;
    logic [BW+WIDTH-1:0] shreg, adj;
    logic [CNTW-1:0]     bit_cnt;
    logic                sat_flag;
    logic [BW-1:0]       disp, disp_next;
    logic [CW-1:0]       bin_ext;
    logic                over;
    logic [WIDTH-1:0]    bin_sat;
    logic [RW-1:0]       refresh_cnt;
    logic                tick;
    logic [SW-1:0]       scan_idx;
    logic [DIGITS-1:0]   blank_vec;
    logic                zero_run;
    logic [3:0]          cur_digit;
    logic                cur_blank;

    assign bin_ext = CW'(bin_in);
    assign over    = (bin_ext > MAXV_EXT);
    assign bin_sat = over ? WIDTH'(MAXV) : bin_in;
    assign busy    = (state != IDLE);
    assign tick    = (refresh_cnt == RW'(REFRESH_DIV - 1));

    // The display register only changes in DONE; the output stage reads this
    // next value so a frame never mixes old and new digits.
    assign disp_next = (state == DONE) ? shreg[BW+WIDTH-1:WIDTH] : disp;

    // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj = shreg;
        for (int k = 0; k < DIGITS; k++) begin
            if (shreg[WIDTH+4*k +: 4] >= 4'd5)
                adj[WIDTH+4*k +: 4] = shreg[WIDTH+4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SHIFT;
            SHIFT:   if (bit_cnt == CNTW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath; the saturated value starts in the low binary part
    // with a cleared BCD accumulator above it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            sat_flag <= 1'b0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            disp <= disp_next;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg    <= {{BW{1'b0}}, bin_sat};
                        bit_cnt  <= CNTW'(WIDTH);
                        sat_flag <= over;
                    end
                end
                SHIFT: begin
                    shreg   <= adj << 1;
                    bit_cnt <= bit_cnt - CNTW'(1);
                end
                DONE: begin
                    overflow <= sat_flag;
                end
                default: ;
            endcase
        end
    end

    // Refresh divider and digit scan index, independent of conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // A digit above the units is blank when it and every higher digit are zero
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        cur_digit = '0;
        cur_blank = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (disp_next[4*k +: 4] == 4'd0);
            blank_vec[k] = blank_lz && (k != 0) && zero_run;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (SW'(k) == scan_idx) begin
                cur_digit = disp_next[4*k +: 4];
                cur_blank = blank_vec[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_en <= '0;
            seg   <= 7'h7F;
        end else if (tick) begin
            an_en <= cur_blank ? '0 : (DIGITS'(1) << scan_idx);
            seg   <= cur_blank ? 7'h7F : decode(cur_digit);
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Self-checking bench for display_scan_ctrl.  Stimulus pushes each expected
// conversion result into a scoreboard queue; a monitor sampling just after
// every clock edge pops results as they complete and compares busy,
// overflow, an_en and seg against an arithmetic model of the display.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int W    = 10;
    localparam int D    = 3;
    localparam int DIV  = 4;
    localparam int MAXV = 999;

    typedef struct {
        int value;
        bit ovf;
        int start;
        int done;
    } conv_t;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  bin_in;
    logic          load;
    logic          blank_lz;
    logic [D-1:0]  an_en;
    logic [6:0]    seg;
    logic          busy;
    logic          overflow;

    conv_t exp_q[$];
    conv_t ent;
    int    tests;
    int    fails;
    int    cyc;
    int    model_disp;
    bit    model_ovf;
    int    exp_an;
    int    exp_seg;
    int    exp_busy;
    int    p10[D];

    display_scan_ctrl #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bin_in   (bin_in),
        .load     (load),
        .blank_lz (blank_lz),
        .an_en    (an_en),
        .seg      (seg),
        .busy     (busy),
        .overflow (overflow)
    );

    // Free-running 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int segCode(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one sample just after each rising edge.  The model tracks the
    // edge count since reset release; digit slots change on every DIV-th edge,
    // and a completed conversion updates the shown value at its own edge.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            exp_q.delete();
            model_disp = 0;
            model_ovf  = 0;
            exp_an     = 0;
            exp_seg    = 7'h7F;
            cyc        = 0;
        end else begin
            cyc++;
            if (exp_q.size() > 0 && exp_q[0].done == cyc) begin
                ent        = exp_q.pop_front();
                model_disp = ent.value;
                model_ovf  = ent.ovf;
                checkOutput("done_overflow", int'(overflow), int'(ent.ovf));
            end
            if (cyc % DIV == 0) begin
                int slot;
                bit blank;
                slot    = ((cyc / DIV) - 1) % D;
                blank   = blank_lz && (slot >= 1) && (model_disp < p10[slot]);
                exp_an  = blank ? 0 : (1 << slot);
                exp_seg = blank ? 7'h7F : segCode((model_disp / p10[slot]) % 10);
            end
        end
        exp_busy = (exp_q.size() > 0 && cyc >= exp_q[0].start) ? 1 : 0;
        checkOutput("busy", int'(busy), exp_busy);
        checkOutput("overflow", int'(overflow), int'(model_ovf));
        checkOutput("an_en", int'(an_en), exp_an);
        checkOutput("seg", int'(seg), exp_seg);
    end

    // Issue one accepted load: waits (bounded) for the previous conversion to
    // finish, then holds load for exactly one rising edge.
    task automatic applyStimulus(input int val);
        conv_t c;
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL idle_wait: still busy after %0d cycles, required idle", guard);
        end
        bin_in  = W'(val);
        load    = 1'b1;
        c.value = (val > MAXV) ? MAXV : val;
        c.ovf   = (val > MAXV);
        c.start = cyc + 1;
        c.done  = cyc + 1 + W + 1;
        exp_q.push_back(c);
        @(negedge clk);
        load = 1'b0;
    endtask

    // A load pulse that lands while the converter is busy and must be ignored
    task automatic pulseIgnoredLoad(input int val, input int delay);
        repeat (delay) @(negedge clk);
        bin_in = W'(val);
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("[TB] FAIL idle_wait: still busy after %0d cycles, required idle", guard);
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        cyc        = 0;
        model_disp = 0;
        model_ovf  = 0;
        exp_an     = 0;
        exp_seg    = 7'h7F;
        exp_busy   = 0;
        p10[0]     = 1;
        for (int k = 1; k < D; k++) p10[k] = p10[k-1] * 10;

        rst_n    = 1'b0;
        load     = 1'b0;
        bin_in   = '0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Blank display scanning zeros
        repeat (2 * D * DIV) @(negedge clk);

        // Full-scale 8-bit value
        applyStimulus(255);
        waitIdle();
        repeat (D * DIV + DIV) @(negedge clk);

        // Leading-zero blanking on and off
        blank_lz = 1'b1;
        applyStimulus(7);
        waitIdle();
        repeat (2 * D * DIV) @(negedge clk);
        blank_lz = 1'b0;
        repeat (D * DIV) @(negedge clk);

        // Saturation and its clearing on the following conversion
        applyStimulus(1000);
        waitIdle();
        repeat (D * DIV) @(negedge clk);
        applyStimulus(42);
        waitIdle();
        repeat (D * DIV) @(negedge clk);

        // Load during busy is dropped
        applyStimulus(100);
        pulseIgnoredLoad(200, 1);
        waitIdle();
        repeat (D * DIV) @(negedge clk);

        // Randomised conversions, gaps, blanking and ignored loads
        for (int n = 0; n < 25; n++) begin
            blank_lz = 1'($urandom_range(0, 1));
            applyStimulus(int'($urandom_range(0, (1 << W) - 1)));
            if ($urandom_range(0, 1) == 1)
                pulseIgnoredLoad(int'($urandom_range(0, (1 << W) - 1)),
                                 int'($urandom_range(0, W - 1)));
            waitIdle();
            repeat ($urandom_range(0, 2 * D * DIV)) @(negedge clk);
        end

        // Asynchronous reset in the middle of a conversion
        blank_lz = 1'b0;
        applyStimulus(1023);
        waitIdle();
        repeat (D * DIV) @(negedge clk);
        applyStimulus(555);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_an_en", int'(an_en), 0);
        checkOutput("async_seg", int'(seg), 7'h7F);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_overflow", int'(overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * D * DIV) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
